// File: rtl/ovl_fire_pkg.sv
// Shared types and constants for the OVL fire collector: FSM states, fire
// vector bit positions and the popcount width helper.
package ovl_fire_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURED = 2'd1,
    CLEAR    = 2'd2
  } state_e;

  localparam int unsigned FIRE_2STATE = 0;
  localparam int unsigned FIRE_XCHECK = 1;
  localparam int unsigned FIRE_COVER  = 2;

  // Bits needed to hold a count of 0..n set checkers in one cycle.
  function automatic int unsigned popcount_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ovl_fire_sat_counter.sv
// Saturating up-counter: adds a multi-bit increment each cycle, sticks at
// all-ones, synchronous clear has priority over the increment.
module ovl_fire_sat_counter #(
  parameter int unsigned width     = 8,
  parameter int unsigned inc_width = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clr,
  input  logic [inc_width-1:0] inc,
  output logic [width-1:0]     count
);

  localparam int unsigned AccW = ((width > inc_width) ? width : inc_width) + 1;

  logic [width-1:0] count_q, count_d;
  logic [AccW-1:0]  sum;

  always_comb begin
    sum     = AccW'(count_q) + AccW'(inc);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (|sum[AccW-1:width]) begin
      count_d = '1;
    end else begin
      count_d = sum[width-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/ovl_fire_collector.sv
// Aggregates OVL checker fire vectors into sticky flags, saturating counters
// and a first-failure record, with a four-phase clear handshake.
module ovl_fire_collector
  import ovl_fire_pkg::*;
#(
  parameter int unsigned num_checkers = 4,
  parameter int unsigned id_width     = 2,
  parameter int unsigned cnt_width    = 8,
  parameter int unsigned ts_width     = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [3*num_checkers-1:0] fire_in,
  input  logic                      clear_req,
  output logic                      clear_ack,
  output logic [num_checkers-1:0]   sticky_2state,
  output logic [num_checkers-1:0]   sticky_xcheck,
  output logic [cnt_width-1:0]      err_count,
  output logic [cnt_width-1:0]      cover_count,
  output logic                      first_valid,
  output logic [id_width-1:0]       first_id,
  output logic [ts_width-1:0]       first_ts,
  output logic                      irq
);

  localparam int unsigned SumW = popcount_width(num_checkers);

  state_e                  state_q, state_d;
  logic [ts_width-1:0]     ts_q, ts_d;
  logic [num_checkers-1:0] st2_q, st2_d, stx_q, stx_d;
  logic                    fv_q, fv_d;
  logic [id_width-1:0]     fid_q, fid_d;
  logic [ts_width-1:0]     fts_q, fts_d;
  logic                    irq_q, irq_d;

  logic [num_checkers-1:0] hit2, hitx, hitc;
  logic [SumW-1:0]         err_inc, cov_inc;
  logic                    clr_take;
  logic                    found;

  // A clear is only accepted from IDLE/CAPTURED; fires on that edge are dropped.
  always_comb begin
    clr_take = (state_q != CLEAR) && clear_req;
    hit2     = '0;
    hitx     = '0;
    hitc     = '0;
    err_inc  = '0;
    cov_inc  = '0;
    for (int unsigned k = 0; k < num_checkers; k++) begin
      hit2[k] = enable && !clr_take && fire_in[3*k+FIRE_2STATE];
      hitx[k] = enable && !clr_take && fire_in[3*k+FIRE_XCHECK];
      hitc[k] = enable && !clr_take && fire_in[3*k+FIRE_COVER];
      err_inc = err_inc + SumW'(hit2[k] | hitx[k]);
      cov_inc = cov_inc + SumW'(hitc[k]);
    end
  end

  always_comb begin
    ts_d  = enable ? ts_q + ts_width'(1) : ts_q;
    st2_d = clr_take ? '0 : (st2_q | hit2);
    stx_d = clr_take ? '0 : (stx_q | hitx);
    irq_d = |{st2_d, stx_d};
    fv_d  = fv_q;
    fid_d = fid_q;
    fts_d = fts_q;
    found = 1'b0;
    if (clr_take) begin
      fv_d  = 1'b0;
      fid_d = '0;
      fts_d = '0;
    end else if (!fv_q && |hit2) begin
      fv_d  = 1'b1;
      fts_d = ts_q;
      for (int unsigned k = 0; k < num_checkers; k++) begin
        if (hit2[k] && !found) begin
          found = 1'b1;
          fid_d = id_width'(k);
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (clear_req)  state_d = CLEAR;
        else if (fv_d)  state_d = CAPTURED;
      end
      CAPTURED: begin
        if (clear_req)  state_d = CLEAR;
      end
      CLEAR: begin
        if (!clear_req) state_d = fv_d ? CAPTURED : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ts_q    <= '0;
      st2_q   <= '0;
      stx_q   <= '0;
      fv_q    <= 1'b0;
      fid_q   <= '0;
      fts_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ts_q    <= ts_d;
      st2_q   <= st2_d;
      stx_q   <= stx_d;
      fv_q    <= fv_d;
      fid_q   <= fid_d;
      fts_q   <= fts_d;
      irq_q   <= irq_d;
    end
  end

  ovl_fire_sat_counter #(
    .width     (cnt_width),
    .inc_width (SumW)
  ) u_err_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (clr_take),
    .inc   (err_inc),
    .count (err_count)
  );

  ovl_fire_sat_counter #(
    .width     (cnt_width),
    .inc_width (SumW)
  ) u_cov_cnt (
    .clock (clock),
    .reset (reset),
    .clr   (clr_take),
    .inc   (cov_inc),
    .count (cover_count)
  );

  assign clear_ack     = (state_q == CLEAR);
  assign sticky_2state = st2_q;
  assign sticky_xcheck = stx_q;
  assign first_valid   = fv_q;
  assign first_id      = fid_q;
  assign first_ts      = fts_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_ovl_fire_collector.sv
// Directed bench for ovl_fire_collector (4 checkers, 4-bit counters, 4-bit
// timestamp) with a behavioural reference model checked every cycle.
module tb_ovl_fire_collector;

  localparam int NC  = 4;
  localparam int CNT_MAX = 15;
  localparam int TS_MOD  = 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic [11:0]   fire_in;
  logic          clear_req;
  logic          clear_ack;
  logic [3:0]    sticky_2state, sticky_xcheck;
  logic [3:0]    err_count, cover_count;
  logic          first_valid;
  logic [1:0]    first_id;
  logic [3:0]    first_ts;
  logic          irq;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ovl_fire_collector #(
    .num_checkers (4),
    .id_width     (2),
    .cnt_width    (4),
    .ts_width     (4)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .fire_in       (fire_in),
    .clear_req     (clear_req),
    .clear_ack     (clear_ack),
    .sticky_2state (sticky_2state),
    .sticky_xcheck (sticky_xcheck),
    .err_count     (err_count),
    .cover_count   (cover_count),
    .first_valid   (first_valid),
    .first_id      (first_id),
    .first_ts      (first_ts),
    .irq           (irq)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integers and flags, updated per rising edge.
  int       m_ts, m_err, m_cov, m_fid, m_fts;
  bit [3:0] m_s2, m_sx;
  bit       m_fv, m_ack, m_irq;
  int       n_err, n_cov;
  bit [2:0] f;

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_ts = 0; m_err = 0; m_cov = 0; m_fid = 0; m_fts = 0;
      m_s2 = '0; m_sx = '0; m_fv = 0; m_ack = 0; m_irq = 0;
    end else begin
      if (!m_ack && clear_req) begin
        m_err = 0; m_cov = 0; m_fid = 0; m_fts = 0;
        m_s2 = '0; m_sx = '0; m_fv = 0; m_ack = 1;
      end else begin
        if (enable) begin
          n_err = 0;
          n_cov = 0;
          for (int k = 0; k < NC; k++) begin
            f = fire_in[3*k +: 3];
            if (f[0]) m_s2[k] = 1'b1;
            if (f[1]) m_sx[k] = 1'b1;
            if (f[0] || f[1]) n_err++;
            if (f[2]) n_cov++;
            if (f[0] && !m_fv) begin
              m_fv  = 1;
              m_fid = k;
              m_fts = m_ts;
            end
          end
          m_err = (m_err + n_err > CNT_MAX) ? CNT_MAX : m_err + n_err;
          m_cov = (m_cov + n_cov > CNT_MAX) ? CNT_MAX : m_cov + n_cov;
        end
        if (m_ack && !clear_req) m_ack = 0;
      end
      m_irq = (m_s2 != 0) || (m_sx != 0);
      if (enable) m_ts = (m_ts + 1) % TS_MOD;
    end
  end

  always @(negedge clock) begin
    if (reset) begin
      chk("m_sticky_2state", 32'(sticky_2state), 32'(m_s2));
      chk("m_sticky_xcheck", 32'(sticky_xcheck), 32'(m_sx));
      chk("m_err_count",     32'(err_count),     32'(m_err));
      chk("m_cover_count",   32'(cover_count),   32'(m_cov));
      chk("m_first_valid",   32'(first_valid),   32'(m_fv));
      chk("m_clear_ack",     32'(clear_ack),     32'(m_ack));
      chk("m_irq",           32'(irq),           32'(m_irq));
      if (m_fv) begin
        chk("m_first_id", 32'(first_id), 32'(m_fid));
        chk("m_first_ts", 32'(first_ts), 32'(m_fts));
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    enable    = 1'b1;
    fire_in   = '0;
    clear_req = 1'b0;
    cyc(2);
    reset = 1'b1;
  endtask

  initial begin
    do_reset();

    // Idle 10 cycles: everything zero, then a fire exposes timestamp 10.
    cyc(10);
    chk("idle_sticky2", 32'(sticky_2state), 32'h0);
    chk("idle_stickyx", 32'(sticky_xcheck), 32'h0);
    chk("idle_err",     32'(err_count),     32'h0);
    chk("idle_cov",     32'(cover_count),   32'h0);
    chk("idle_fv",      32'(first_valid),   32'h0);
    chk("idle_irq",     32'(irq),           32'h0);
    chk("idle_ack",     32'(clear_ack),     32'h0);
    fire_in = 12'h001;
    cyc(1);
    fire_in = '0;
    chk("ts10_first_ts", 32'(first_ts), 32'd10);

    // Checker 2 at ts 5, checker 1 at ts 7.
    do_reset();
    cyc(5);
    fire_in = 12'h040;
    cyc(1);
    fire_in = '0;
    chk("first_irq",   32'(irq),         32'h1);
    chk("first_fv",    32'(first_valid), 32'h1);
    chk("first_id_2",  32'(first_id),    32'd2);
    chk("first_ts_5",  32'(first_ts),    32'd5);
    cyc(1);
    fire_in = 12'h008;
    cyc(1);
    fire_in = '0;
    chk("keep_id_2",   32'(first_id),      32'd2);
    chk("keep_ts_5",   32'(first_ts),      32'd5);
    chk("sticky_0110", 32'(sticky_2state), 32'h6);
    chk("err_2",       32'(err_count),     32'd2);

    // Checkers 0 and 3 together: lowest index wins.
    do_reset();
    fire_in = 12'h201;
    cyc(1);
    fire_in = '0;
    chk("tie_id_0",  32'(first_id),      32'd0);
    chk("tie_err_2", 32'(err_count),     32'd2);
    chk("tie_st",    32'(sticky_2state), 32'h9);

    // Cover saturation at 15.
    do_reset();
    fire_in = 12'h924;
    cyc(3);
    chk("cov_12", 32'(cover_count), 32'd12);
    cyc(2);
    chk("cov_sat", 32'(cover_count), 32'd15);
    cyc(2);
    fire_in = '0;
    chk("cov_hold", 32'(cover_count), 32'd15);
    chk("cov_no_irq", 32'(irq), 32'h0);

    // Clear handshake with a coincident xcheck fire, then capture in CLEAR.
    fire_in = 12'h002;
    cyc(1);
    chk("x_sticky", 32'(sticky_xcheck), 32'h1);
    chk("x_irq",    32'(irq),           32'h1);
    clear_req = 1'b1;
    fire_in   = 12'h010;
    cyc(1);
    fire_in = '0;
    chk("clr_ack",    32'(clear_ack),     32'h1);
    chk("clr_stx",    32'(sticky_xcheck), 32'h0);
    chk("clr_err",    32'(err_count),     32'h0);
    chk("clr_cov",    32'(cover_count),   32'h0);
    chk("clr_irq",    32'(irq),           32'h0);
    fire_in = 12'h200;
    cyc(1);
    fire_in = '0;
    chk("clr_fv",     32'(first_valid), 32'h1);
    chk("clr_fid",    32'(first_id),    32'd3);
    chk("clr_ack_hi", 32'(clear_ack),   32'h1);
    cyc(1);
    chk("clr_no_reclear", 32'(err_count), 32'd1);
    clear_req = 1'b0;
    cyc(1);
    chk("rel_ack", 32'(clear_ack),   32'h0);
    chk("rel_fv",  32'(first_valid), 32'h1);
    fire_in = 12'h001;
    cyc(1);
    fire_in = '0;
    chk("no_overwrite", 32'(first_id), 32'd3);

    // Timestamp wrap (17 cycles -> 1), then enable low with fires.
    do_reset();
    cyc(17);
    enable  = 1'b0;
    fire_in = 12'hFFF;
    cyc(8);
    chk("dis_st2", 32'(sticky_2state), 32'h0);
    chk("dis_err", 32'(err_count),     32'h0);
    chk("dis_cov", 32'(cover_count),   32'h0);
    chk("dis_fv",  32'(first_valid),   32'h0);
    enable  = 1'b1;
    fire_in = 12'h008;
    cyc(1);
    fire_in = '0;
    chk("wrap_ts", 32'(first_ts), 32'd1);
    chk("wrap_id", 32'(first_id), 32'd1);

    // Reset in the middle of a handshake drops clear_ack at once.
    clear_req = 1'b1;
    cyc(1);
    chk("mid_ack", 32'(clear_ack), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_ack", 32'(clear_ack), 32'h0);
    chk("async_fv",  32'(first_valid), 32'h0);
    clear_req = 1'b0;
    cyc(2);
    reset = 1'b1;
    cyc(2);
    chk("post_ack", 32'(clear_ack), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
